// File: rtl/sram_rd_sched.sv
// -----------------------------------------------------------------------------
// sram_rd_sched
//
// Round-robin scheduler that shares one synchronous-read SRAM port between two
// burst requesters. A requester presents a base address and a word count. The
// winner's burst is read out of the SRAM one word per cycle. The returned words
// are streamed on a valid/ready interface, tagged with the owning requester id
// and a last-beat flag.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous reset, active high
//   req0_valid     requester 0 has a burst pending
//   req0_ready     requester 0 burst accepted this cycle (combinational)
//   req0_base      requester 0 start address
//   req0_len       requester 0 word count
//   req1_*         same as requester 0, for requester 1
//   sram_en        SRAM read enable
//   sram_addr      SRAM read address
//   sram_dout      SRAM read data, valid one cycle after sram_en and held
//                  while sram_en is low
//   rd_data        streamed word (wired straight from sram_dout)
//   rd_valid       rd_data is valid
//   rd_ready       consumer accepts the beat
//   rd_id          requester that owns the current beat
//   rd_last        final beat of the burst
//   done           one-cycle pulse when a burst completes or is rejected
//   err            one-cycle pulse when a burst is rejected
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sram_rd_sched #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 9,
    parameter int LEN_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_W-1:0]     req0_base,
    input  logic [LEN_W-1:0]      req0_len,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_W-1:0]     req1_base,
    input  logic [LEN_W-1:0]      req1_len,

    output logic                  sram_en,
    output logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_dout,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_id,
    output logic                  rd_last,

    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Depth compared with one extra bit so DEPTH == 2**ADDR_W still works.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  ONE_L     = LEN_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic                prio_reg, prio_next;
    logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
    logic [LEN_W-1:0]    cnt_reg, cnt_next;
    logic                rd_valid_reg, rd_valid_next;
    logic                rd_last_reg, rd_last_next;
    logic                rd_id_reg, rd_id_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;

    // -------------------------------------------------------------------------
    // Requester arbitration
    // -------------------------------------------------------------------------
    logic [1:0]          req_valid;
    logic [ADDR_W-1:0]   req_base [2];
    logic [LEN_W-1:0]    req_len  [2];
    logic [1:0]          grant;
    logic                win_id;
    logic [ADDR_W-1:0]   win_base;
    logic [LEN_W-1:0]    win_len;
    logic                can_accept;
    logic                accept;
    logic                bad_req;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_base[0] = req0_base;
    assign req_base[1] = req1_base;
    assign req_len[0]  = req0_len;
    assign req_len[1]  = req1_len;

    // A lone requester always wins; on contention the priority pointer decides.
    assign win_id   = (req_valid == 2'b11) ? prio_reg : req_valid[1];
    assign win_base = req_base[win_id];
    assign win_len  = req_len[win_id];

    // The completion pulse cycle is still owned by the previous burst, so a new
    // burst is only taken from the cycle after done.
    assign can_accept = (state_reg == IDLE) && !done_reg && !rst;
    assign accept     = can_accept && (|req_valid);

    assign bad_req = ({1'b0, win_base} >= DEPTH_X) || (win_len == '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = accept && (win_id == (gi != 0));
        end
    endgenerate

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // -------------------------------------------------------------------------
    // SRAM issue and output handshake
    // -------------------------------------------------------------------------
    logic issue_ok;
    logic issue;
    logic handshake;

    // A new read may only be launched when the output slot is free or is being
    // emptied this cycle; this keeps sram_dout stable under back-pressure.
    assign issue_ok  = !rd_valid_reg || rd_ready;
    assign issue     = (state_reg == BURST) && issue_ok;
    assign handshake = rd_valid_reg && rd_ready;

    assign sram_en   = issue && !rst;
    assign sram_addr = cur_addr_reg;

    assign rd_data   = sram_dout;
    assign rd_valid  = rd_valid_reg;
    assign rd_last   = rd_last_reg;
    assign rd_id     = rd_id_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        prio_next     = prio_reg;
        cur_addr_next = cur_addr_reg;
        cnt_next      = cnt_reg;
        rd_valid_next = rd_valid_reg;
        rd_last_next  = rd_last_reg;
        rd_id_next    = rd_id_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cur_addr_next = win_base;
                    cnt_next      = win_len;
                    rd_id_next    = win_id;
                    prio_next     = !win_id;
                    if (bad_req) begin
                        // Rejected burst: report it and never touch the SRAM.
                        err_next  = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        state_next = BURST;
                    end
                end
            end

            BURST: begin
                if (issue) begin
                    cnt_next      = cnt_reg - ONE_L;
                    cur_addr_next = (cur_addr_reg == LAST_ADDR) ? '0
                                                                : cur_addr_reg + ONE_A;
                    if (cnt_reg == ONE_L) begin
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (handshake && rd_last_reg) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // The beat produced by an issue appears one cycle later, together with
        // the SRAM data; a handshake without a new issue empties the slot.
        if (issue) begin
            rd_valid_next = 1'b1;
            rd_last_next  = (cnt_reg == ONE_L);
        end else if (handshake) begin
            rd_valid_next = 1'b0;
            rd_last_next  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            prio_reg     <= 1'b0;
            cur_addr_reg <= '0;
            cnt_reg      <= '0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            rd_id_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prio_reg     <= prio_next;
            cur_addr_reg <= cur_addr_next;
            cnt_reg      <= cnt_next;
            rd_valid_reg <= rd_valid_next;
            rd_last_reg  <= rd_last_next;
            rd_id_reg    <= rd_id_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

endmodule

// File: tb/tb_sram_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_sram_rd_sched
//
// Self-checking bench for sram_rd_sched. A transaction-level reference model
// (priority bit, queue of expected beats, pending done/err pulses) is checked
// every cycle. Directed bursts come from a table of expected results; reset in
// mid-burst is a hand-written sequence; a randomized phase closes the run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sram_rd_sched;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 9;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [AW-1:0] req0_base;
    logic [LW-1:0] req0_len;
    logic          req1_valid, req1_ready;
    logic [AW-1:0] req1_base;
    logic [LW-1:0] req1_len;
    logic          sram_en;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready, rd_id, rd_last;
    logic          done, err;

    always #5 clk = ~clk;

    sram_rd_sched #(
        .DATA_WIDTH (DW),
        .ADDR_W     (AW),
        .DEPTH      (DEPTH),
        .LEN_W      (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_base  (req0_base),
        .req0_len   (req0_len),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_base  (req1_base),
        .req1_len   (req1_len),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_dout  (sram_dout),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_id      (rd_id),
        .rd_last    (rd_last),
        .done       (done),
        .err        (err)
    );

    // Synchronous-read SRAM: data appears the cycle after EN and is held.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (sram_en) sram_dout <= mem[sram_addr];
    end

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic [DW-1:0] data;
        logic          id;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic          m_prio;
    logic          m_done_now;
    logic          m_err_now;
    int            idle_wait;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            en_cnt = 0;
    logic [DW-1:0] got_q[$];

    // Per-cycle observations for the directed tasks.
    logic          s_acc, s_acc_id, s_valid, s_done, s_err, s_hs;
    int            s_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // One clock cycle: inputs were driven at the preceding negedge; sample,
    // compare with the model, advance the model, then wait for the next negedge.
    task automatic cycle();
        logic can, wid, any, nd, ne;
        int   base, len;
        #1;
        s_cyc    = cyc;
        s_acc    = 1'b0;
        s_acc_id = 1'b0;
        s_valid  = rd_valid;
        s_done   = done;
        s_err    = err;
        s_hs     = 1'b0;
        nd       = 1'b0;
        ne       = 1'b0;
        if (rst) begin
            chk("req0_ready in reset", {31'd0, req0_ready}, 0);
            chk("req1_ready in reset", {31'd0, req1_ready}, 0);
            chk("sram_en in reset", {31'd0, sram_en}, 0);
            exp_q.delete();
            m_prio     = 1'b0;
            m_done_now = 1'b0;
            m_err_now  = 1'b0;
            idle_wait  = 0;
            s_valid    = 1'b0;
            s_done     = 1'b0;
            s_err      = 1'b0;
        end else begin
            chk("done", {31'd0, done}, {31'd0, m_done_now});
            chk("err", {31'd0, err}, {31'd0, m_err_now});
            any = req0_valid | req1_valid;
            can = (exp_q.size() == 0) && !m_done_now;
            wid = (req0_valid && req1_valid) ? m_prio : req1_valid;
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, can && any && !wid});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, can && any && wid});
            if (exp_q.size() == 0) chk("sram_en while idle", {31'd0, sram_en}, 0);
            if (sram_en) en_cnt++;
            if (rd_valid) begin
                idle_wait = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected beat", {31'd0, rd_valid}, 0);
                end else begin
                    chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q[0].data});
                    chk("rd_id", {31'd0, rd_id}, {31'd0, exp_q[0].id});
                    chk("rd_last", {31'd0, rd_last}, {31'd0, exp_q[0].last});
                    if (rd_ready) begin
                        s_hs = 1'b1;
                        got_q.push_back(rd_data);
                        if (exp_q[0].last) nd = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end else if (exp_q.size() != 0) begin
                idle_wait++;
                if (idle_wait > 6) begin
                    fail_now("beat timeout");
                    idle_wait = 0;
                end
            end
            if (can && any) begin
                s_acc    = 1'b1;
                s_acc_id = wid;
                m_prio   = !wid;
                base     = wid ? int'(req1_base) : int'(req0_base);
                len      = wid ? int'(req1_len)  : int'(req0_len);
                if (base >= DEPTH || len == 0) begin
                    nd = 1'b1;
                    ne = 1'b1;
                end else begin
                    for (int i = 0; i < len; i++)
                        exp_q.push_back('{data: mem[(base + i) % DEPTH], id: wid, last: (i == len - 1)});
                end
            end
            m_done_now = nd;
            m_err_now  = ne;
        end
        cyc++;
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        logic          v0;
        logic [AW-1:0] b0;
        logic [LW-1:0] l0;
        logic          v1;
        logic [AW-1:0] b1;
        logic [LW-1:0] l1;
        int            stall;     // beat index after which rd_ready drops 3 cycles, -1 none
        logic          exp_id;
        logic          exp_err;
        int            exp_n;
        logic [31:0]   exp_data;  // beat j in bits [8j+7:8j]
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input string nm);
        int   stall_left, t_acc, t_first, t_done;
        logic wid, werr;
        bit   stalled;
        logic [31:0] dv;
        stall_left = 0; t_acc = -1; t_first = -1; t_done = -1;
        wid = 1'b0; werr = 1'b0; stalled = 1'b0;
        dv = v.exp_data;
        got_q.delete();
        en_cnt = 0;
        req0_valid = v.v0; req0_base = v.b0; req0_len = v.l0;
        req1_valid = v.v1; req1_base = v.b1; req1_len = v.l1;
        for (int i = 0; i < 80 && t_done < 0; i++) begin
            rd_ready = (stall_left == 0);
            cycle();
            if (s_acc && t_acc < 0) begin
                t_acc = s_cyc;
                wid   = s_acc_id;
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            if (s_valid && t_first < 0) t_first = s_cyc;
            if (s_done) begin
                t_done = s_cyc;
                werr   = s_err;
            end
            if (stall_left > 0) stall_left--;
            else if (s_hs && !stalled && v.stall >= 0 && got_q.size() == v.stall + 1) begin
                stall_left = 3;
                stalled    = 1'b1;
            end
        end
        rd_ready   = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (t_done < 0) begin
            fail_now({nm, " no done"});
        end else begin
            chk({nm, " winner"}, {31'd0, wid}, {31'd0, v.exp_id});
            chk({nm, " err"}, {31'd0, werr}, {31'd0, v.exp_err});
            chk({nm, " beats"}, got_q.size(), v.exp_n);
            for (int j = 0; j < v.exp_n && j < got_q.size(); j++)
                chk($sformatf("%s beat%0d", nm, j), {24'd0, got_q[j]}, {24'd0, dv[8*j +: 8]});
            chk({nm, " sram_en count"}, en_cnt, v.exp_n);
            if (!v.exp_err) chk({nm, " first latency"}, t_first - t_acc, 2);
            if (v.stall < 0)
                chk({nm, " done latency"}, t_done - t_acc, v.exp_err ? 1 : v.exp_n + 2);
        end
        $display("vec %s: id=%0d err=%0d beats=%0d acc@%0d done@%0d", nm, wid, werr, got_q.size(), t_acc, t_done);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        vec_t v6;
        mem = '{8'd3, 8'd1, 8'd2, 8'd6, 8'd0, 8'd5, 8'd0, 8'd0, 8'd3,
                8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};

        //         v0    b0    l0    v1    b1    l1   stall id    err   n  data
        vecs[0] = '{1'b1, 4'd5, 4'd2, 1'b1, 4'd5, 4'd2, -1, 1'b0, 1'b0, 2, 32'h0000_0005};
        vecs[1] = '{1'b1, 4'd5, 4'd2, 1'b1, 4'd5, 4'd2, -1, 1'b1, 1'b0, 2, 32'h0000_0005};
        vecs[2] = '{1'b1, 4'd0, 4'd4, 1'b0, 4'd0, 4'd0, -1, 1'b0, 1'b0, 4, 32'h0602_0103};
        vecs[3] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd3,  0, 1'b1, 1'b0, 3, 32'h0000_0602};
        vecs[4] = '{1'b1, 4'd7, 4'd4, 1'b0, 4'd0, 4'd0, -1, 1'b0, 1'b0, 4, 32'h0103_0300};
        vecs[5] = '{1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, -1, 1'b0, 1'b1, 0, 32'h0000_0000};
        vecs[6] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 4'd2, -1, 1'b1, 1'b1, 0, 32'h0000_0000};
        vecs[7] = '{1'b1, 4'd3, 4'd1, 1'b1, 4'd1, 4'd1, -1, 1'b0, 1'b0, 1, 32'h0000_0006};
        vecs[8] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd8, 4'd3, -1, 1'b1, 1'b0, 3, 32'h0001_0303};

        rst = 1'b1;
        req0_valid = 1'b0; req0_base = '0; req0_len = '0;
        req1_valid = 1'b0; req1_base = '0; req1_len = '0;
        rd_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;

        #1;
        chk("reset rd_valid", {31'd0, rd_valid}, 0);
        chk("reset rd_last", {31'd0, rd_last}, 0);
        chk("reset rd_id", {31'd0, rd_id}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset err", {31'd0, err}, 0);
        chk("reset sram_en", {31'd0, sram_en}, 0);
        cycle();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during the third beat of a 6-word burst.
        got_q.delete();
        req0_valid = 1'b1; req0_base = 4'd0; req0_len = 4'd6;
        rd_ready = 1'b1;
        for (int i = 0; i < 20 && got_q.size() < 2; i++) begin
            cycle();
            if (s_acc) req0_valid = 1'b0;
        end
        req0_valid = 1'b0;
        chk("t6 third beat valid", {31'd0, rd_valid}, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("t6 rd_valid after rst", {31'd0, rd_valid}, 0);
        chk("t6 sram_en after rst", {31'd0, sram_en}, 0);
        chk("t6 done after rst", {31'd0, done}, 0);
        $display("t6: reset applied mid-burst at cycle %0d", cyc);
        for (int i = 0; i < 4; i++) cycle();
        v6 = '{1'b1, 4'd0, 4'd1, 1'b0, 4'd0, 4'd0, -1, 1'b0, 1'b0, 1, 32'h0000_0003};
        run_vec(v6, "t6_fresh");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_base  = AW'($urandom_range(0, 10));
            req1_base  = AW'($urandom_range(0, 10));
            req0_len   = LW'($urandom_range(0, 7));
            req1_len   = LW'($urandom_range(0, 12));
            rd_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) cycle();
        chk("random drain empty", exp_q.size(), 0);
        $display("random phase complete at cycle %0d", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
